// File: rtl/kc_ls1u_dbus_arb_if.sv
// Bus bundle for the KC_LS1u_plus data-port arbiter: CPU port, DMA port and shared memory port.
// master = arbiter view, slave = CPU/DMA/memory side view.
interface kc_ls1u_dbus_arb_if #(
   parameter int unsigned AW = 24,
   parameter int unsigned DW = 8
);
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_we;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_wait;

   logic          dma_req;
   logic          dma_lock;
   logic [AW-1:0] dma_addr;
   logic          dma_we;
   logic [DW-1:0] dma_wdata;
   logic [DW-1:0] dma_rdata;
   logic          dma_ack;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [1:0]    owner;

   modport master (
      input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
      output cpu_rdata, cpu_wait,
      input  dma_req, dma_lock, dma_addr, dma_we, dma_wdata,
      output dma_rdata, dma_ack,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata,
      output owner
   );

   modport slave (
      output cpu_req, cpu_addr, cpu_we, cpu_wdata,
      input  cpu_rdata, cpu_wait,
      output dma_req, dma_lock, dma_addr, dma_we, dma_wdata,
      input  dma_rdata, dma_ack,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata,
      input  owner
   );
endinterface

// File: rtl/kc_ls1u_dbus_arb.sv
// Round-robin CPU/DMA arbiter for one data memory with WS wait states per access.
// Optional DMA burst locking is built when DBUS_ARB_BURST_EN is defined.
module kc_ls1u_dbus_arb #(
   parameter int unsigned AW        = 24,
   parameter int unsigned DW        = 8,
   parameter int unsigned WS        = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   kc_ls1u_dbus_arb_if.master    bus
);

   if (WS > 15) begin : g_ws_chk
      $error("kc_ls1u_dbus_arb: WS must be in 0..15");
   end

   typedef enum logic {StIdle, StAcc} state_e;

   localparam logic [1:0] OwnNone = 2'b00;
   localparam logic [1:0] OwnCpu  = 2'b01;
   localparam logic [1:0] OwnDma  = 2'b10;
   localparam logic [3:0] WsCnt   = 4'(WS);

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic [1:0]    owner_q;
   logic          last_dma_q;
   logic [AW-1:0] addr_hold_q;
   logic [DW-1:0] wdata_hold_q;

   logic          in_acc, own_req, own_we, done, abort;
   logic          other_req, burst_hold, take;
   logic [1:0]    other, rr_win, take_who;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

`ifdef DBUS_ARB_BURST_EN
   localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   logic [BW-1:0] beats_q;
   logic          beats_room;
   assign beats_room = beats_q < BW'(MAX_BURST - 1);
   // Locked DMA keeps the bus until the burst budget is spent and the CPU is waiting.
   assign burst_hold = (owner_q == OwnDma) & bus.dma_lock & (beats_room | ~bus.cpu_req);
`else
   localparam int unsigned UnusedMaxBurst = MAX_BURST;
   logic unused_lock;
   assign unused_lock = bus.dma_lock;
   assign burst_hold  = 1'b0;
`endif

   always_comb begin
      in_acc    = (state_q == StAcc);
      own_req   = 1'b0;
      own_we    = 1'b0;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      other     = OwnDma;
      other_req = bus.dma_req;
      case (owner_q)
         OwnCpu: begin
            own_req = bus.cpu_req;
            own_we  = bus.cpu_we;
         end
         OwnDma: begin
            own_req   = bus.dma_req;
            own_we    = bus.dma_we;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
            other     = OwnCpu;
            other_req = bus.cpu_req;
         end
         default: ;
      endcase
      done  = in_acc & own_req & (cnt_q == 4'd0);
      abort = in_acc & ~own_req;

      if (bus.cpu_req & bus.dma_req) rr_win = last_dma_q ? OwnCpu : OwnDma;
      else                           rr_win = bus.cpu_req ? OwnCpu : OwnDma;

      take     = 1'b0;
      take_who = OwnNone;
      if (!in_acc && (bus.cpu_req || bus.dma_req)) begin
         take     = 1'b1;
         take_who = rr_win;
      end else if (done && !burst_hold && other_req) begin
         // Hand over in the completion cycle so back-to-back masters see no bubble.
         take     = 1'b1;
         take_who = other;
      end
   end

   assign bus.owner     = owner_q;
   assign bus.mem_addr  = in_acc ? sel_addr : addr_hold_q;
   assign bus.mem_wdata = in_acc ? sel_wdata : wdata_hold_q;
   assign bus.mem_we    = done & own_we;
   assign bus.cpu_wait  = bus.cpu_req & ~(in_acc & (owner_q == OwnCpu) & (cnt_q == 4'd0));
   assign bus.cpu_rdata = (done && owner_q == OwnCpu) ? bus.mem_rdata : '0;
   assign bus.dma_rdata = (done && owner_q == OwnDma) ? bus.mem_rdata : '0;
   assign bus.dma_ack   = done & (owner_q == OwnDma);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         owner_q      <= OwnNone;
         last_dma_q   <= 1'b1;
         addr_hold_q  <= '0;
         wdata_hold_q <= '0;
`ifdef DBUS_ARB_BURST_EN
         beats_q      <= '0;
`endif
      end else begin
         if (in_acc) begin
            addr_hold_q  <= sel_addr;
            wdata_hold_q <= sel_wdata;
         end
         if (take) begin
            state_q    <= StAcc;
            cnt_q      <= WsCnt;
            owner_q    <= take_who;
            last_dma_q <= (take_who == OwnDma);
`ifdef DBUS_ARB_BURST_EN
            if (take_who == OwnCpu) beats_q <= '0;
`endif
         end else if (done && burst_hold) begin
            cnt_q <= WsCnt;
`ifdef DBUS_ARB_BURST_EN
            beats_q <= beats_room ? beats_q + 1'b1 : '0;
`endif
         end else if (done || abort) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
         end else if (in_acc) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_kc_ls1u_dbus_arb.sv
// Self-checking bench for kc_ls1u_dbus_arb: directed scenarios plus random CPU/DMA traffic
// checked every cycle against a transaction-level model (burst rules when DBUS_ARB_BURST_EN).
module tb_kc_ls1u_dbus_arb;
   localparam int unsigned AW = 24;
   localparam int unsigned DW = 8;
   localparam int unsigned WS = 1;
   localparam int unsigned MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   kc_ls1u_dbus_arb_if #(.AW(AW), .DW(DW)) bus ();

   kc_ls1u_dbus_arb #(.AW(AW), .DW(DW), .WS(WS), .MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory behind the arbiter, plus an independent copy the model keeps up to date.
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic       mem_init = 1'b0;
   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'hA5 : 8'(i * 37 + 5);
         mem_init <= 1'b1;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   // Model: who holds the bus, how many cycles of the access have elapsed, round-robin memory.
   int            m_own, m_el, m_last, m_beats;
   logic [AW-1:0] m_hold_a;
   logic [7:0]    m_hold_w;
   logic          m_cdone, m_ddone;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_own = 0; m_el = 0; m_last = 2; m_beats = 0;
      m_hold_a = '0; m_hold_w = '0; m_cdone = 1'b0; m_ddone = 1'b0;
   endtask

   // Called at posedge+1 with inputs already set; checks this cycle, then advances one clock.
   task automatic step(output logic o_cw, output logic o_ack, output logic o_we,
                       output logic [1:0] o_own, output logic [7:0] o_rd, output logic [7:0] o_wd);
      int            own, oth, n_own, n_el, n_last, n_beats;
      logic          oreq, owe, comp, abrt, keep, oth_req;
      logic [AW-1:0] oa;
      logic [7:0]    ow;
      #1;
      own  = m_own;
      oreq = (own == 1) ? bus.cpu_req : (own == 2) ? bus.dma_req : 1'b0;
      owe  = (own == 2) ? bus.dma_we : bus.cpu_we;
      oa   = (own == 2) ? bus.dma_addr : bus.cpu_addr;
      ow   = (own == 2) ? bus.dma_wdata : bus.cpu_wdata;
      comp = (own != 0) && oreq && (m_el == WS);
      abrt = (own != 0) && !oreq;

      check("owner", bus.owner, own);
      check("cpu_wait", bus.cpu_wait, bus.cpu_req && !(own == 1 && m_el == WS));
      check("dma_ack", bus.dma_ack, comp && own == 2);
      check("mem_we", bus.mem_we, comp && owe);
      check("mem_addr", bus.mem_addr, (own != 0) ? oa : m_hold_a);
      check("mem_wdata", bus.mem_wdata, (own != 0) ? ow : m_hold_w);
      check("cpu_rdata", bus.cpu_rdata, (comp && own == 1) ? ref_mem[oa[7:0]] : 8'h00);
      check("dma_rdata", bus.dma_rdata, (comp && own == 2) ? ref_mem[oa[7:0]] : 8'h00);
      o_cw = bus.cpu_wait; o_ack = bus.dma_ack; o_we = bus.mem_we;
      o_own = bus.owner; o_rd = bus.cpu_rdata; o_wd = bus.mem_wdata;
      m_cdone = comp && own == 1;
      m_ddone = comp && own == 2;

      n_own = own; n_el = m_el; n_last = m_last; n_beats = m_beats;
      if (own == 0) begin
         if (bus.cpu_req || bus.dma_req) begin
            if (bus.cpu_req && bus.dma_req) n_own = (m_last == 2) ? 1 : 2;
            else                            n_own = bus.cpu_req ? 1 : 2;
            n_el = 0; n_last = n_own;
            if (n_own == 1) n_beats = 0;
         end
      end else if (abrt) begin
         n_own = 0;
      end else if (!comp) begin
         n_el = m_el + 1;
      end else begin
         if (owe) ref_mem[oa[7:0]] = ow;
         n_el = 0;
         keep = 1'b0;
`ifdef DBUS_ARB_BURST_EN
         if (own == 2 && bus.dma_lock && (m_beats < MAX_BURST - 1 || !bus.cpu_req)) begin
            keep = 1'b1;
            n_beats = (m_beats < MAX_BURST - 1) ? m_beats + 1 : 0;
         end
`endif
         if (!keep) begin
            oth = 3 - own;
            oth_req = (oth == 1) ? bus.cpu_req : bus.dma_req;
            if (oth_req) begin
               n_own = oth; n_last = oth;
               if (oth == 1) n_beats = 0;
            end else begin
               n_own = 0;
            end
         end
      end
      if (own != 0) begin
         m_hold_a = oa; m_hold_w = ow;
      end
      @(posedge clk);
      m_own = n_own; m_el = n_el; m_last = n_last; m_beats = n_beats;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic       cw, ack, we;
   logic [1:0] ow;
   logic [7:0] rd, wd;
   logic [1:0] own_seq [8];
   int         cnt, acks;
   logic [7:0] wd_seen;
   logic       got_cpu;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = (i == 16) ? 8'hA5 : 8'(i * 37 + 5);
      model_reset();
      bus.cpu_req = 1'b1; bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_lock = 1'b0; bus.dma_addr = '0; bus.dma_we = 1'b0;
      bus.dma_wdata = '0;

      // Reset values, cpu_wait follows cpu_req combinationally.
      repeat (2) @(posedge clk);
      #2;
      check("rst_owner", bus.owner, 2'b00);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_dma_ack", bus.dma_ack, 1'b0);
      check("rst_cpu_wait_hi", bus.cpu_wait, 1'b1);
      check("rst_mem_addr", bus.mem_addr, 24'h0);
      check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
      bus.cpu_req = 1'b0;
      #1;
      check("rst_cpu_wait_lo", bus.cpu_wait, 1'b0);
      do_reset();

      // CPU read alone: two stall cycles, data in the third.
      bus.cpu_req = 1'b1; bus.cpu_addr = 24'h000010; bus.cpu_we = 1'b0;
      step(cw, ack, we, ow, rd, wd); check("rd_t0_wait", cw, 1'b1);
      step(cw, ack, we, ow, rd, wd); check("rd_t1_wait", cw, 1'b1);
      step(cw, ack, we, ow, rd, wd); check("rd_t2_wait", cw, 1'b0);
      check("rd_t2_data", rd, 8'hA5);
      bus.cpu_req = 1'b0;
      step(cw, ack, we, ow, rd, wd);

      // CPU write: exactly one strobe carrying the data.
      bus.cpu_req = 1'b1; bus.cpu_addr = 24'h000020; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h3C;
      cnt = 0; wd_seen = 8'h00;
      for (int i = 0; i < 6; i++) begin
         step(cw, ack, we, ow, rd, wd);
         if (we) begin cnt++; wd_seen = wd; end
         if (m_cdone) bus.cpu_req = 1'b0;
      end
      check("wr_pulses", cnt, 1);
      check("wr_data", wd_seen, 8'h3C);
      check("wr_mem", mem[8'h20], 8'h3C);

      // Reset in the middle of a DMA write: no strobe, bus released at once.
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 24'h000030; bus.dma_wdata = 8'h77;
      step(cw, ack, we, ow, rd, wd);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_we", bus.mem_we, 1'b0);
      check("rst_mid_owner", bus.owner, 2'b00);
      check("rst_mid_ack", bus.dma_ack, 1'b0);
      bus.dma_req = 1'b0;
      do_reset();
      check("rst_mid_mem", mem[8'h30], ref_mem[8'h30]);

      // Simultaneous requests: CPU first, then DMA, then CPU again.
      bus.cpu_req = 1'b1; bus.cpu_addr = 24'h000040; bus.cpu_we = 1'b0;
      bus.dma_req = 1'b1; bus.dma_addr = 24'h000041; bus.dma_we = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(cw, ack, we, ow, rd, wd);
         own_seq[i] = ow;
         if (m_cdone) begin
            cnt++;
            if (cnt == 1) bus.cpu_addr = 24'h000042;
            else bus.cpu_req = 1'b0;
         end
         if (m_ddone) bus.dma_req = 1'b0;
      end
      check("rr_first_cpu", own_seq[1], 2'b01);
      check("rr_then_dma", own_seq[3], 2'b10);
      check("rr_back_cpu", own_seq[5], 2'b01);

      // DMA abandons its access while CPU waits.
      do_reset();
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 24'h000050; bus.dma_wdata = 8'h11;
      step(cw, ack, we, ow, rd, wd);
      bus.dma_req = 1'b0; bus.cpu_req = 1'b1; bus.cpu_addr = 24'h000051; bus.cpu_we = 1'b0;
      step(cw, ack, we, ow, rd, wd);
      check("abort_we", we, 1'b0);
      check("abort_ack", ack, 1'b0);
      step(cw, ack, we, ow, rd, wd);
      step(cw, ack, we, ow, rd, wd);
      check("abort_cpu_owner", ow, 2'b01);
      for (int i = 0; i < 4 && bus.cpu_req; i++) begin
         step(cw, ack, we, ow, rd, wd);
         if (m_cdone) bus.cpu_req = 1'b0;
      end
      check("abort_mem", mem[8'h50], ref_mem[8'h50]);

`ifdef DBUS_ARB_BURST_EN
      // Locked DMA burst holds off a waiting CPU for MAX_BURST beats.
      do_reset();
      bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 24'h000060; bus.dma_we = 1'b0;
      step(cw, ack, we, ow, rd, wd);
      bus.cpu_req = 1'b1; bus.cpu_addr = 24'h000061; bus.cpu_we = 1'b0;
      acks = 0; got_cpu = 1'b0;
      for (int i = 0; i < 40 && !got_cpu; i++) begin
         step(cw, ack, we, ow, rd, wd);
         if (ow == 2'b01) got_cpu = 1'b1;
         else if (ack) begin acks++; bus.dma_addr = bus.dma_addr + 24'd1; end
      end
      check("burst_cpu_grant", got_cpu, 1'b1);
      check("burst_acks", acks, MAX_BURST);
      bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
      for (int i = 0; i < 4 && bus.cpu_req; i++) begin
         step(cw, ack, we, ow, rd, wd);
         if (m_cdone) bus.cpu_req = 1'b0;
      end
`endif

      // Random traffic from both masters, including DMA aborts.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (bus.cpu_req && m_cdone) bus.cpu_req = 1'b0;
         if (!bus.cpu_req && $urandom_range(2) == 0) begin
            bus.cpu_req = 1'b1; bus.cpu_addr = 24'($urandom);
            bus.cpu_we = 1'($urandom); bus.cpu_wdata = 8'($urandom);
         end
         if (bus.dma_req) begin
            if (m_ddone || $urandom_range(19) == 0) bus.dma_req = 1'b0;
         end else if ($urandom_range(2) == 0) begin
            bus.dma_req = 1'b1; bus.dma_addr = 24'($urandom);
            bus.dma_we = 1'($urandom); bus.dma_wdata = 8'($urandom);
         end
         bus.dma_lock = 1'($urandom);
         step(cw, ack, we, ow, rd, wd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
